// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and FSM state
// encodings plus the MUL/DIV class decode used by the pipeline stall logic.
package mdu_iter_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   // Ops 0..3 occupy the unit for many cycles; MTHI/MTLO/NOP never do.
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Execute-stage <-> MDU bundle: issue request, flush, and HI/LO/status back.
interface mdu_iter_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/mdu_iter_div_step.sv
// One restoring-divide step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it did not borrow.
module mdu_iter_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   part_rem,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);
   logic [WIDTH:0] diff_s;

   // Trial subtraction; the top bit of the difference is the borrow.
   always_comb begin
      diff_s = part_rem - {1'b0, divisor};
      if (diff_s[WIDTH]) begin
         q_bit    = 1'b0;
         next_rem = part_rem[WIDTH-1:0];
      end else begin
         q_bit    = 1'b1;
         next_rem = diff_s[WIDTH-1:0];
      end
   end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO. One result bit
// per cycle on magnitudes; signs are reapplied in FIN.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   mdu_iter_if.slave bus
);
   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e               state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]     dvsr_r;
   logic                 is_div_r;
   logic                 sign_r;
   logic                 rem_neg_r;
   logic                 div0_r;
   logic                 busy_r;
   logic                 done_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;

   op_e                  op_s;
   logic                 signed_op_s;
   logic                 div_op_s;
   logic                 a_neg_s;
   logic                 b_neg_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic [WIDTH-1:0]     mul_addend_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH-1:0]   mul_next_s;
   logic [WIDTH-1:0]     div_rem_s;
   logic                 div_qbit_s;
   logic [2*WIDTH-1:0]   div_next_s;
   logic [2*WIDTH-1:0]   prod_fix_s;
   logic [WIDTH-1:0]     quo_fix_s;
   logic [WIDTH-1:0]     rem_fix_s;

   // Accumulator holds {remainder, dividend/quotient}; top WIDTH+1 bits are the shifted remainder.
   mdu_iter_div_step #(.WIDTH(WIDTH)) u_div_step (
      .part_rem (acc_r[2*WIDTH-1:WIDTH-1]),
      .divisor  (dvsr_r),
      .next_rem (div_rem_s),
      .q_bit    (div_qbit_s)
   );

   // Issue-side decode and operand magnitudes.
   always_comb begin
      op_s        = op_e'(bus.op);
      signed_op_s = (op_s == OP_MULT) || (op_s == OP_DIV);
      div_op_s    = (op_s == OP_DIV)  || (op_s == OP_DIVU);
      a_neg_s     = signed_op_s && bus.a[WIDTH-1];
      b_neg_s     = signed_op_s && bus.b[WIDTH-1];
      if (a_neg_s) begin
         a_mag_s = ~bus.a + WIDTH'(1'b1);
      end else begin
         a_mag_s = bus.a;
      end
      if (b_neg_s) begin
         b_mag_s = ~bus.b + WIDTH'(1'b1);
      end else begin
         b_mag_s = bus.b;
      end
   end

   // Per-cycle datapath steps and final sign correction.
   always_comb begin
      if (acc_r[0]) begin
         mul_addend_s = dvsr_r;
      end else begin
         mul_addend_s = '0;
      end
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend_s};
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      div_next_s = {div_rem_s, acc_r[WIDTH-2:0], div_qbit_s};

      if (sign_r) begin
         prod_fix_s = ~acc_r + (2*WIDTH)'(1'b1);
      end else begin
         prod_fix_s = acc_r;
      end
      // Divide by zero forces an all-ones quotient; the remainder path already yields a.
      if (div0_r) begin
         quo_fix_s = '1;
      end else if (sign_r) begin
         quo_fix_s = ~acc_r[WIDTH-1:0] + WIDTH'(1'b1);
      end else begin
         quo_fix_s = acc_r[WIDTH-1:0];
      end
      if (rem_neg_r) begin
         rem_fix_s = ~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1'b1);
      end else begin
         rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM, iteration state and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         cnt_r     <= '0;
         acc_r     <= '0;
         dvsr_r    <= '0;
         is_div_r  <= 1'b0;
         sign_r    <= 1'b0;
         rem_neg_r <= 1'b0;
         div0_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         hi_r      <= '0;
         lo_r      <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start && !bus.flush) begin
                  case (op_s)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        state_r   <= S_RUN;
                        busy_r    <= 1'b1;
                        cnt_r     <= '0;
                        is_div_r  <= div_op_s;
                        sign_r    <= a_neg_s ^ b_neg_s;
                        rem_neg_r <= a_neg_s;
                        div0_r    <= div_op_s && (bus.b == '0);
                        dvsr_r    <= div_op_s ? b_mag_s : a_mag_s;
                        acc_r     <= {{WIDTH{1'b0}}, (div_op_s ? a_mag_s : b_mag_s)};
                     end
                     OP_MTHI: hi_r <= bus.a;
                     OP_MTLO: lo_r <= bus.a;
                     default: state_r <= S_IDLE;
                  endcase
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_RUN: begin
               if (bus.flush) begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  acc_r <= is_div_r ? div_next_s : mul_next_s;
                  cnt_r <= cnt_r + CNT_W'(1'b1);
                  if (cnt_r == LAST_CNT) begin
                     state_r <= S_FIN;
                  end else begin
                     state_r <= S_RUN;
                  end
               end
            end
            S_FIN: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               if (!bus.flush) begin
                  done_r <= 1'b1;
                  if (is_div_r) begin
                     hi_r <= rem_fix_s;
                     lo_r <= quo_fix_s;
                  end else begin
                     hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                     lo_r <= prod_fix_s[WIDTH-1:0];
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.hi    = hi_r;
   assign bus.lo    = lo_r;
   assign bus.stall = busy_r | (bus.start & is_muldiv(bus.op));

endmodule
